pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 125 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with a registered in_ready.
// Define PIPE_STAGE_SKID_CNT_EN to build the stall/flush event counters.
module pipe_stage_skid #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 64,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_ready_q;
  logic              accept, take;
  logic              load_main_in, load_main_skid, load_skid;

  assign accept    = in_valid & in_ready_q & ~flush;
  assign out_valid = (state != EMPTY);
  assign take      = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_ctrl  = out_valid ? main_ctrl : NOP_CTRL;
  assign out_data  = main_data;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && take) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (take) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is derived from the next state so it never depends on out_ready combinationally
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_ctrl  <= NOP_CTRL;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_SKID_CNT_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
      if (flush && flush_q != 16'hFFFF) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios, then randomized traffic.
// Counter expectations follow PIPE_STAGE_SKID_CNT_EN.
module tb_pipe_stage_skid;

  localparam int             CW  = 8;
  localparam int             DW  = 64;
  localparam logic [CW-1:0]  NOP = 8'h5A;

  logic          clk_50MHz = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt, flush_cnt;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            started = 1'b0;
  logic [DW-1:0] last_data = '0;
  int            stall_exp = 0;
  int            flush_exp = 0;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .NOP_CTRL(NOP)) dut (
    .clk_50MHz(clk_50MHz),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One cycle of inputs, driven just after the rising edge
  task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic ordy, input logic fl, input logic r);
    @(posedge clk_50MHz);
    #2;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  // Record each accepted entry late in the cycle, after the monitor has checked
  always @(negedge clk_50MHz) begin : recorder
    entry_t e;
    #5;
    if (started && rst && in_valid && in_ready && !flush) begin
      e.ctrl = in_ctrl;
      e.data = in_data;
      exp_q.push_back(e);
    end
  end

  // The queue holds exactly the entries the stage should be carrying this cycle
  always @(negedge clk_50MHz) begin : monitor
    if (started) begin
      checkOutput("mon_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      checkOutput("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        checkOutput("mon_out_ctrl", 64'(out_ctrl), 64'(exp_q[0].ctrl));
        checkOutput("mon_out_data", out_data, exp_q[0].data);
      end else begin
        checkOutput("mon_bubble_ctrl", 64'(out_ctrl), 64'(NOP));
        checkOutput("mon_hold_data", out_data, last_data);
      end
`ifdef PIPE_STAGE_SKID_CNT_EN
      checkOutput("mon_stall_cnt", 64'(stall_cnt), 64'(stall_exp));
      checkOutput("mon_flush_cnt", 64'(flush_cnt), 64'(flush_exp));
`else
      checkOutput("mon_stall_cnt", 64'(stall_cnt), 64'd0);
      checkOutput("mon_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    end
    if (!rst) begin
      exp_q.delete();
      last_data = '0;
      stall_exp = 0;
      flush_exp = 0;
      started   = 1'b1;
    end else if (started) begin
      if (exp_q.size() > 0) last_data = exp_q[0].data;
      if (exp_q.size() > 0 && !out_ready && stall_exp < 65535) stall_exp++;
      if (flush && flush_exp < 65535) flush_exp++;
      if (flush) exp_q.delete();
      else if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'(NOP));
    checkOutput("rst_out_data", out_data, 64'd0);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, CW'(i) ^ 8'hC0, DW'(i), 1'b1, 1'b0, 1'b1);
      checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 1) begin
        checkOutput("stream_out_valid", 64'(out_valid), 64'd1);
        checkOutput("stream_out_data", out_data, 64'(i - 1));
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("stream_last_data", out_data, 64'd8);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("stream_bubble_valid", 64'(out_valid), 64'd0);
    checkOutput("stream_bubble_ctrl", 64'(out_ctrl), 64'(NOP));
    checkOutput("stream_hold_data", out_data, 64'd8);

    // Backpressure into FULL, then drain
    applyStimulus(1'b1, 8'h01, 64'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h02, 64'h22, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_full_data", out_data, 64'h11);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_stable_data", out_data, 64'h11);
    checkOutput("bp_stable_ctrl", 64'(out_ctrl), 64'h01);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_second_data", out_data, 64'h22);
    checkOutput("bp_second_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_drained_valid", 64'(out_valid), 64'd0);

    // Flush while FULL with a competing input
    applyStimulus(1'b1, 8'h04, 64'h44, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h05, 64'h55, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h03, 64'h33, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_out_ctrl", 64'(out_ctrl), 64'(NOP));
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_SKID_CNT_EN
    checkOutput("flush_cnt_one", 64'(flush_cnt), 64'd1);
`else
    checkOutput("flush_cnt_off", 64'(flush_cnt), 64'd0);
`endif

    // Reset for one cycle while FULL
    applyStimulus(1'b1, 8'h06, 64'h66, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h07, 64'h77, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("rstfull_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rstfull_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rstfull_out_data", out_data, 64'd0);
    checkOutput("rstfull_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("rstfull_flush_cnt", 64'(flush_cnt), 64'd0);

    // Five stalled cycles with one entry held
    applyStimulus(1'b1, 8'h08, 64'h88, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_STAGE_SKID_CNT_EN
    checkOutput("stall_cnt_five", 64'(stall_cnt), 64'd5);
`else
    checkOutput("stall_cnt_off", 64'(stall_cnt), 64'd0);
`endif
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 10000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, CW'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                    $urandom_range(0, 511) != 0);
    end

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("drain_out_valid", 64'(out_valid), 64'd0);
    checkOutput("drain_in_ready", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
